sram_bus_ctrl: RTL and testbench

- Bus-cycle controller that owns the direction of the 16-bit bidirectional external-SRAM data bus.
- Turns single-word read/write requests from the PicoBlaze port decoder into timed async-SRAM cycles.
- Drives the tristate buffer's output data (buf_i) and enable (buf_t), and samples its input side (buf_o).
- Guarantees no bus contention: a turnaround cycle is inserted between a read and a following write.

---
 rtl/sram_bus_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_sram_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl -- bus-cycle controller for an async 16-bit external SRAM.
//
// Turns single-word read/write requests into timed SRAM cycles and owns the
// direction of the bidirectional data bus through an external tristate
// buffer (buf_i toward the pad, buf_o from the pad, buf_t = 1 releases it).
// A TURN cycle separates a read from a following write so the SRAM output
// driver and our buffer never fight over the bus.
//
// Every SRAM-facing output is a flop fed straight from the FSM, so strobes,
// buf_t and buf_i cannot glitch.
//
// Optional build macro: SRAM_BYTE_LANE_EN
//   defined   -> adds i_be[1:0] and o_sram_ub_n / o_sram_lb_n byte enables
//   undefined -> no byte-enable ports; every write is a full word
//
// WAIT_CYC sets how many cycles OE_n / WE_n stay low (legal 1..15).

module sram_bus_ctrl #(
  parameter int ADDR_W   = 18,
  parameter int WAIT_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic [15:0]       o_buf_i,
  output logic              o_buf_t,
  input  logic [15:0]       i_buf_o
`ifdef SRAM_BYTE_LANE_EN
  ,
  input  logic [1:0]        i_be,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_TURN     = 3'd2,
    S_WR_SETUP = 3'd3,
    S_WR_PULSE = 3'd4,
    S_WR_HOLD  = 3'd5
  } state_t;

  // Counter counts down to zero, so a strobe of WAIT_CYC cycles loads WAIT_CYC-1.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_last_rd;
  logic                r_busy;
  logic                r_done;
  logic [15:0]         r_rdata;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic [15:0]         r_buf_i;
  logic                r_buf_t;

  // Registered outputs go straight to the ports.
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_sram_addr = r_sram_addr;
  assign o_sram_ce_n = r_ce_n;
  assign o_sram_oe_n = r_oe_n;
  assign o_sram_we_n = r_we_n;
  assign o_buf_i     = r_buf_i;
  assign o_buf_t     = r_buf_t;

  // Bus-cycle FSM: outputs are set on the edge that enters each state, so
  // they are valid for the whole state without any decode after the flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_last_rd   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rdata     <= 16'd0;
      r_sram_addr <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_buf_i     <= 16'd0;
      r_buf_t     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            // Address and write data are captured here and never again
            // until the next accept, so bus-side changes while busy are inert.
            r_sram_addr <= i_addr;
            r_busy      <= 1'b1;
            if (!i_we) begin
              r_state <= S_RD;
              r_cnt   <= CNT_LOAD;
              r_ce_n  <= 1'b0;
              r_oe_n  <= 1'b0;
            end else begin
              r_buf_i <= i_wdata;
              if (r_last_rd) begin
                // SRAM may still be driving the bus after OE_n rose: idle a cycle.
                r_state <= S_TURN;
              end else begin
                r_state <= S_WR_SETUP;
                r_ce_n  <= 1'b0;
                r_buf_t <= 1'b0;
              end
            end
          end
        end

        S_RD: begin
          if (r_cnt == 4'd0) begin
            r_rdata   <= i_buf_o;
            r_done    <= 1'b1;
            r_last_rd <= 1'b1;
            r_busy    <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_TURN: begin
          r_state <= S_WR_SETUP;
          r_ce_n  <= 1'b0;
          r_buf_t <= 1'b0;
        end

        S_WR_SETUP: begin
          // Data has been on the bus for a full cycle before WE_n falls.
          r_state <= S_WR_PULSE;
          r_cnt   <= CNT_LOAD;
          r_we_n  <= 1'b0;
        end

        S_WR_PULSE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_WR_HOLD;
            r_we_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_WR_HOLD: begin
          // Data stays driven one cycle past WE_n rising for hold time.
          r_state   <= S_IDLE;
          r_ce_n    <= 1'b1;
          r_buf_t   <= 1'b1;
          r_done    <= 1'b1;
          r_last_rd <= 1'b0;
          r_busy    <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_buf_t <= 1'b1;
        end
      endcase
    end
  end

`ifdef SRAM_BYTE_LANE_EN
  logic [1:0] r_be;
  logic       r_ub_n;
  logic       r_lb_n;

  assign o_sram_ub_n = r_ub_n;
  assign o_sram_lb_n = r_lb_n;

  // Byte-lane enables track the FSM: both lanes on for reads, be-selected
  // lanes across the write phases, both off otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_be   <= 2'b11;
      r_ub_n <= 1'b1;
      r_lb_n <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_be <= i_be;
            if (!i_we)
              {r_ub_n, r_lb_n} <= 2'b00;
            else if (!r_last_rd)
              {r_ub_n, r_lb_n} <= ~i_be;
          end
        end
        S_TURN:    {r_ub_n, r_lb_n} <= ~r_be;
        S_RD:      if (r_cnt == 4'd0) {r_ub_n, r_lb_n} <= 2'b11;
        S_WR_HOLD: {r_ub_n, r_lb_n} <= 2'b11;
        default:   ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb_sram_bus_ctrl -- self-checking bench for sram_bus_ctrl (WAIT_CYC=2).
// A small pad model stores written words and returns them on reads; an
// optional override forces the value the pad returns. Every accepted request
// pushes its expected latency / rdata / address onto a scoreboard that the
// done-pulse monitor pops.

module tb_sram_bus_ctrl;
  localparam int AW = 18;
  localparam int WC = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          req   = 1'b0;
  logic          we    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [15:0]   wdata = 16'd0;
  logic          busy, done, ce_n, oe_n, we_n, buf_t;
  logic [15:0]   rdata, buf_i, buf_o;
  logic [AW-1:0] sram_addr;
`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]    be = 2'b11;
  logic          ub_n, lb_n;
`endif

  always #5 clk = ~clk;

  sram_bus_ctrl #(.ADDR_W(AW), .WAIT_CYC(WC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_rdata(rdata),
    .o_sram_addr(sram_addr), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
    .o_sram_we_n(we_n), .o_buf_i(buf_i), .o_buf_t(buf_t), .i_buf_o(buf_o)
`ifdef SRAM_BYTE_LANE_EN
    , .i_be(be), .o_sram_ub_n(ub_n), .o_sram_lb_n(lb_n)
`endif
  );

  // Pad model
  logic [15:0] mem [0:255];
  logic        pad_ovr_en = 1'b0;
  logic [15:0] pad_ovr    = 16'd0;
  assign buf_o = !oe_n ? (pad_ovr_en ? pad_ovr : mem[sram_addr[7:0]]) : 16'h0BAD;
  always @(posedge clk) if (rst_n && !ce_n && !we_n) mem[sram_addr[7:0]] <= buf_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct {
    bit            is_wr;
    int            acc;
    logic [15:0]   rd;
    logic [AW-1:0] a;
    int            lat;
  } exp_t;
  exp_t sbq[$];

  int          cyc = 0;
  int          oe_lo = 0, we_lo = 0, bt_lo = 0, bufi_bad = 0, done_cnt = 0, turn_cnt = 0;
  logic [15:0] exp_bufi = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: per-cycle bus statistics, contention checks, done-pulse scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (!oe_n)  oe_lo++;
      if (!we_n)  we_lo++;
      if (!buf_t) bt_lo++;
      if (!buf_t && buf_i !== exp_bufi) bufi_bad++;
      if (busy && ce_n && oe_n && we_n && buf_t) turn_cnt++;
      chk("oe_we_overlap", 32'(!oe_n && !we_n), 32'd0);
      chk("drive_while_oe", 32'(!oe_n && !buf_t), 32'd0);
      if (done) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e   = sbq.pop_front();
          lat = cyc - e.acc + 1;
          chk(e.is_wr ? "wr_latency" : "rd_latency", 32'(lat), 32'(e.lat));
          chk("rdata", 32'(rdata), 32'(e.rd));
          chk("sram_addr", 32'(sram_addr), 32'(e.a));
        end
      end
    end
  end

  // Present a request and hold req until it is accepted; returns at the
  // negedge of the first busy cycle with req still high.
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input int lat);
    int n = 0;
    we = w; addr = a; wdata = d; req = 1'b1;
    if (w) exp_bufi = d;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) chk("accept_timeout", 32'd1, 32'd0);
    sbq.push_back('{w, cyc + 1, exp_rd, a, lat});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    req = 1'b0;
    while ((busy || sbq.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (busy || sbq.size() != 0) chk("done_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic [15:0]   rd;
    int            lat;
  } vec_t;

  initial begin
    vec_t vt[9];
    int   b_oe, b_we, b_bt, b_bufi, b_done, b_turn;

    // Writes after a read carry the TURN cycle (latency 6), otherwise 5.
    // rd column is the rdata value expected when each done pulses.
    vt[0] = '{1'b1, 18'h00020, 16'h1357, 16'hCCFF, 6};
    vt[1] = '{1'b1, 18'h00021, 16'h2468, 16'hCCFF, 5};
    vt[2] = '{1'b0, 18'h00020, 16'h0000, 16'h1357, 3};
    vt[3] = '{1'b0, 18'h00021, 16'h0000, 16'h2468, 3};
    vt[4] = '{1'b1, 18'h3FFFF, 16'hFFFF, 16'h2468, 6};
    vt[5] = '{1'b0, 18'h3FFFF, 16'h0000, 16'hFFFF, 3};
    vt[6] = '{1'b1, 18'h00000, 16'h0000, 16'hFFFF, 6};
    vt[7] = '{1'b0, 18'h00000, 16'h0000, 16'h0000, 3};
    vt[8] = '{1'b0, 18'h00020, 16'h0000, 16'h1357, 3};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_addr",  32'(sram_addr), 32'd0);
    chk("rst_buf_i", 32'(buf_i), 32'd0);
    chk("rst_strobes", 32'({ce_n, oe_n, we_n}), 32'h7);
    chk("rst_buf_t", 32'(buf_t), 32'd1);
`ifdef SRAM_BYTE_LANE_EN
    chk("rst_lanes", 32'({ub_n, lb_n}), 32'h3);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Write from IDLE with no prior read
    b_oe = oe_lo; b_we = we_lo; b_bt = bt_lo; b_bufi = bufi_bad;
    issue(1'b1, 18'h00020, 16'h4433, 16'h0000, WC + 3);
    wait_idle();
    chk("wr_buf_t_cycles", 32'(bt_lo - b_bt), 32'd4);
    chk("wr_we_cycles",    32'(we_lo - b_we), 32'd2);
    chk("wr_oe_cycles",    32'(oe_lo - b_oe), 32'd0);
    chk("wr_buf_i_value",  32'(bufi_bad - b_bufi), 32'd0);

    // Read with pad returning 0xAABB
    pad_ovr_en = 1'b1; pad_ovr = 16'hAABB;
    b_oe = oe_lo; b_bt = bt_lo;
    issue(1'b0, 18'h00010, 16'h0000, 16'hAABB, WC + 1);
    wait_idle();
    chk("rd_oe_cycles",    32'(oe_lo - b_oe), 32'd2);
    chk("rd_buf_t_cycles", 32'(bt_lo - b_bt), 32'd0);
    chk("rd_value",        32'(rdata), 32'hAABB);

    // Read then write back-to-back with req held through done
    b_turn = turn_cnt; b_done = done_cnt; b_bufi = bufi_bad;
    issue(1'b0, 18'h00010, 16'h0000, 16'hAABB, WC + 1);
    issue(1'b1, 18'h00011, 16'h0022, 16'hAABB, WC + 4);
    pad_ovr_en = 1'b0;
    wait_idle();
    chk("turn_cycles", 32'(turn_cnt - b_turn), 32'd1);
    chk("b2b_dones",   32'(done_cnt - b_done), 32'd2);
    chk("b2b_buf_i",   32'(bufi_bad - b_bufi), 32'd0);

    // req pulses while busy are ignored
    b_done = done_cnt; b_we = we_lo; b_bufi = bufi_bad;
    issue(1'b1, 18'h00040, 16'h5555, 16'hAABB, WC + 3);
    we = 1'b0; addr = 18'h00041; wdata = 16'h9999; req = 1'b1;
    @(negedge clk);
    chk("busy_addr_hold1", 32'(sram_addr), 32'h40);
    @(negedge clk);
    req = 1'b0;
    chk("busy_addr_hold2", 32'(sram_addr), 32'h40);
    wait_idle();
    chk("busy_one_done",  32'(done_cnt - b_done), 32'd1);
    chk("busy_still_wr",  32'(we_lo - b_we), 32'd2);
    chk("busy_buf_i",     32'(bufi_bad - b_bufi), 32'd0);
    issue(1'b0, 18'h00040, 16'h0000, 16'h5555, WC + 1);
    wait_idle();

    // Reset asserted during WR_PULSE (cycle 3: TURN, SETUP, PULSE)
    issue(1'b1, 18'h00030, 16'h7777, 16'h5555, WC + 4);
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_we_low", 32'(we_n), 32'd0);
    b_done = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_we_n",  32'(we_n),  32'd1);
    chk("rst_mid_buf_t", 32'(buf_t), 32'd1);
    chk("rst_mid_busy",  32'(busy),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_cnt - b_done), 32'd0);
    chk("rst_mid_rdata",   32'(rdata), 32'd0);
    pad_ovr_en = 1'b1; pad_ovr = 16'hCCFF;
    issue(1'b0, 18'h00030, 16'h0000, 16'hCCFF, WC + 1);
    wait_idle();
    pad_ovr_en = 1'b0;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      issue(vt[i].w, vt[i].a, vt[i].d, vt[i].rd, vt[i].lat);
      wait_idle();
    end

`ifdef SRAM_BYTE_LANE_EN
    // Lower-lane-only write after a read
    be = 2'b01;
    issue(1'b1, 18'h00050, 16'h1234, 16'h1357, WC + 4);
    req = 1'b0;
    for (int n = 0; n < 8 && busy; n++) begin
      if (!buf_t) chk("lane_wr", 32'({ub_n, lb_n}), 32'h2);
      else        chk("lane_turn", 32'({ub_n, lb_n}), 32'h3);
      @(negedge clk);
    end
    wait_idle();
    chk("lane_idle", 32'({ub_n, lb_n}), 32'h3);
    be = 2'b11;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

endmodule
